// File: rtl/mtm_alu_pkg.sv
// Shared protocol constants, FSM state type and CTL-byte helpers for the mtm_Alu serial link.
package mtm_alu_pkg;

   localparam int FRAME_BITS  = 11;
   localparam int DATA_FRAMES = 4;

   localparam logic TYPE_DATA = 1'b0;
   localparam logic TYPE_CTL  = 1'b1;

   // x^3 + x + 1 with the x^3 term implied
   localparam logic [2:0] CRC3_POLY = 3'b011;

   // err_flags layout: the three error causes appear twice
   localparam int ERR_DATA_A = 5;
   localparam int ERR_CRC_A  = 4;
   localparam int ERR_OP_A   = 3;
   localparam int ERR_DATA_B = 2;
   localparam int ERR_CRC_B  = 1;
   localparam int ERR_OP_B   = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      TYPE  = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } ser_state_e;

   function automatic logic [2:0] crc3_serial(input logic [36:0] msg);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ msg[i];
         crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
      end
      return crc;
   endfunction

   function automatic logic even_par7(input logic [6:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Request/serial-output bundle between the ALU core and the transmit serializer.
interface mtm_alu_serializer_if;

   logic        valid;
   logic [31:0] C;
   logic [3:0]  flags;
   logic        err;
   logic [5:0]  err_flags;
   logic        sout;
   logic        busy;

   modport master (
      output valid, C, flags, err, err_flags,
      input  sout, busy
   );

   modport slave (
      input  valid, C, flags, err, err_flags,
      output sout, busy
   );

endinterface

// File: rtl/mtm_alu_ctl_gen.sv
// Combinational response CTL byte: CRC3 over {C, 0, flags} for results, even parity for errors.
module mtm_alu_ctl_gen
   import mtm_alu_pkg::*;
(
   input  logic [31:0] c,
   input  logic [3:0]  flags,
   input  logic        err,
   input  logic [5:0]  err_flags,
   output logic [7:0]  ctl
);

   logic [2:0] crc_s;
   logic       par_s;

   // select result or error CTL encoding
   always_comb begin
      crc_s = crc3_serial({c, 1'b0, flags});
      par_s = even_par7({1'b1, err_flags});
      if (err) begin
         ctl = {1'b1, err_flags, par_s};
      end else begin
         ctl = {1'b0, flags, crc_s};
      end
   end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Transmit side of the mtm_Alu link: latches one ALU result or error report and shifts
// it out as 11-bit frames on the idle-high sout line.
module mtm_alu_serializer
   import mtm_alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   mtm_alu_serializer_if.slave  bus
);

   ser_state_e  state_r, state_nxt_s;
   logic [2:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic [2:0]  frame_cnt_r, frame_cnt_nxt_s;
   logic [7:0]  shift_r, shift_nxt_s;
   logic [31:0] c_r, c_nxt_s;
   logic [7:0]  ctl_r, ctl_nxt_s;
   logic        err_r, err_nxt_s;
   logic        sout_r, sout_nxt_s;
   logic        busy_r, busy_nxt_s;

   logic [7:0]  ctl_in_s;
   logic [7:0]  payload_s;
   logic        last_frame_s;
   logic        accept_s;

   mtm_alu_ctl_gen u_ctl_gen (
      .c         (bus.C),
      .flags     (bus.flags),
      .err       (bus.err),
      .err_flags (bus.err_flags),
      .ctl       (ctl_in_s)
   );

   // payload byte of the current frame and last-frame detection
   always_comb begin
      last_frame_s = err_r || (frame_cnt_r == 3'(DATA_FRAMES));
      if (last_frame_s) begin
         payload_s = ctl_r;
      end else begin
         case (frame_cnt_r)
            3'd0:    payload_s = c_r[31:24];
            3'd1:    payload_s = c_r[23:16];
            3'd2:    payload_s = c_r[15:8];
            3'd3:    payload_s = c_r[7:0];
            default: payload_s = ctl_r;
         endcase
      end
   end

   // a new request may also land on the edge that closes the final stop bit
   always_comb begin
      accept_s = bus.valid && ((state_r == IDLE) || ((state_r == STOP) && last_frame_s));
   end

   // next-state and next-output logic; the state names what sout shows after the edge
   always_comb begin
      state_nxt_s     = state_r;
      bit_cnt_nxt_s   = bit_cnt_r;
      frame_cnt_nxt_s = frame_cnt_r;
      shift_nxt_s     = shift_r;
      c_nxt_s         = c_r;
      ctl_nxt_s       = ctl_r;
      err_nxt_s       = err_r;
      sout_nxt_s      = 1'b1;

      if (accept_s) begin
         state_nxt_s     = START;
         bit_cnt_nxt_s   = 3'd0;
         frame_cnt_nxt_s = 3'd0;
         c_nxt_s         = bus.C;
         ctl_nxt_s       = ctl_in_s;
         err_nxt_s       = bus.err;
         sout_nxt_s      = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_nxt_s = IDLE;
               sout_nxt_s  = 1'b1;
            end
            START: begin
               state_nxt_s = TYPE;
               sout_nxt_s  = last_frame_s ? TYPE_CTL : TYPE_DATA;
            end
            TYPE: begin
               state_nxt_s   = DATA;
               bit_cnt_nxt_s = 3'd7;
               sout_nxt_s    = payload_s[7];
               shift_nxt_s   = {payload_s[6:0], 1'b0};
            end
            DATA: begin
               if (bit_cnt_r == 3'd0) begin
                  state_nxt_s = STOP;
                  sout_nxt_s  = 1'b1;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r - 3'd1;
                  sout_nxt_s    = shift_r[7];
                  shift_nxt_s   = {shift_r[6:0], 1'b0};
               end
            end
            STOP: begin
               if (last_frame_s) begin
                  state_nxt_s = IDLE;
                  sout_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s     = START;
                  frame_cnt_nxt_s = frame_cnt_r + 3'd1;
                  sout_nxt_s      = 1'b0;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               sout_nxt_s  = 1'b1;
            end
         endcase
      end

      busy_nxt_s = (state_nxt_s != IDLE);
   end

   // state, datapath and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         bit_cnt_r   <= 3'd0;
         frame_cnt_r <= 3'd0;
         shift_r     <= 8'd0;
         c_r         <= 32'd0;
         ctl_r       <= 8'd0;
         err_r       <= 1'b0;
         sout_r      <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         bit_cnt_r   <= bit_cnt_nxt_s;
         frame_cnt_r <= frame_cnt_nxt_s;
         shift_r     <= shift_nxt_s;
         c_r         <= c_nxt_s;
         ctl_r       <= ctl_nxt_s;
         err_r       <= err_nxt_s;
         sout_r      <= sout_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus.sout = sout_r;
   assign bus.busy = busy_r;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed plus randomized bench for mtm_alu_serializer with a frame-level reference model
// and a deserializer-style decoder.
module tb_mtm_alu_serializer;
   import mtm_alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mtm_alu_serializer_if bus();

   mtm_alu_serializer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   pass_cnt = 0;
   int   fail_cnt = 0;
   int   check_cnt = 0;
   int   busy_cycles;
   logic got_b[$];
   logic exp_b[$];

   localparam int RES_BITS = FRAME_BITS * (DATA_FRAMES + 1);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      check_cnt++;
      assert (obs === expv) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // CRC as polynomial long division of M(x)*x^3 by x^3+x+1
   function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
      logic [39:0] r;
      r = {c, 1'b0, f, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      return r[2:0];
   endfunction

   function automatic logic [7:0] ref_ctl(input logic [31:0] c, input logic [3:0] f,
                                          input logic e, input logic [5:0] ef);
      if (e) return {1'b1, ef, (($countones({1'b1, ef}) % 2) == 1) ? 1'b1 : 1'b0};
      return {1'b0, f, ref_crc(c, f)};
   endfunction

   task automatic push_frame(input logic t, input logic [7:0] p);
      exp_b.push_back(1'b0);
      exp_b.push_back(t);
      for (int i = 7; i >= 0; i--) exp_b.push_back(p[i]);
      exp_b.push_back(1'b1);
   endtask

   task automatic build_exp(input logic [31:0] c, input logic [3:0] f,
                            input logic e, input logic [5:0] ef);
      exp_b.delete();
      if (!e)
         for (int k = 0; k < DATA_FRAMES; k++) push_frame(TYPE_DATA, c[31 - 8*k -: 8]);
      push_frame(TYPE_CTL, ref_ctl(c, f, e, ef));
   endtask

   task automatic drive(input logic [31:0] c, input logic [3:0] f,
                        input logic e, input logic [5:0] ef);
      bus.valid = 1'b1;
      bus.C = c;
      bus.flags = f;
      bus.err = e;
      bus.err_flags = ef;
   endtask

   task automatic scramble();
      bus.valid = 1'b0;
      bus.C = $urandom;
      bus.flags = 4'($urandom);
      bus.err = 1'($urandom);
      bus.err_flags = 6'($urandom);
   endtask

   task automatic send(input logic [31:0] c, input logic [3:0] f,
                       input logic e, input logic [5:0] ef);
      @(negedge clk);
      drive(c, f, e, ef);
      @(posedge clk);
      #1;
      scramble();
   endtask

   // record n sout bits; optionally raise valid with other data while sample pulse_at is shown
   task automatic capture(input int n, input int pulse_at, input logic [31:0] pc,
                          input logic [3:0] pf, input logic pe, input logic [5:0] pef);
      got_b.delete();
      busy_cycles = 0;
      for (int k = 0; k < n; k++) begin
         got_b.push_back(bus.sout);
         if (bus.busy === 1'b1) busy_cycles++;
         if (k == pulse_at) drive(pc, pf, pe, pef);
         @(posedge clk);
         #1;
         if (k == pulse_at) scramble();
      end
   endtask

   task automatic check_bits(input string tag);
      int mism;
      mism = 0;
      check({tag, "_len"}, got_b.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
         if (got_b[i] !== exp_b[i]) mism++;
      check({tag, "_bits"}, mism, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_sout"}, bus.sout, 1'b1);
   endtask

   task automatic decode(output logic ok, output logic [31:0] dc, output logic [7:0] dctl);
      int   nf;
      int   b;
      logic [7:0] p;
      ok = 1'b1;
      dc = 32'd0;
      dctl = 8'd0;
      nf = got_b.size() / FRAME_BITS;
      if (nf == 0 || got_b.size() != nf * FRAME_BITS) ok = 1'b0;
      for (int f = 0; f < nf; f++) begin
         b = f * FRAME_BITS;
         if (got_b[b] !== 1'b0 || got_b[b + 10] !== 1'b1) ok = 1'b0;
         if (got_b[b + 1] !== ((f == nf - 1) ? TYPE_CTL : TYPE_DATA)) ok = 1'b0;
         for (int i = 0; i < 8; i++) p[7 - i] = got_b[b + 2 + i];
         if (f == nf - 1) dctl = p;
         else dc = {dc[23:0], p};
      end
   endtask

   initial begin
      logic        ok;
      logic [31:0] dc, rc;
      logic [7:0]  dctl;
      logic [3:0]  rf;
      logic [5:0]  efs [3];
      logic [7:0]  ectl [3];

      scramble();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // all-zero result packet
      build_exp(32'h0000_0000, 4'h0, 1'b0, 6'h00);
      send(32'h0000_0000, 4'h0, 1'b0, 6'h00);
      check("zero_latency_start", bus.sout, 1'b0);
      capture(RES_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
      check_bits("zero_pkt");
      check("zero_busy_cycles", busy_cycles, 55);
      check_idle("zero_end");

      // C = 1: last data byte 0x01 and CRC 3'b010
      build_exp(32'h0000_0001, 4'h0, 1'b0, 6'h00);
      send(32'h0000_0001, 4'h0, 1'b0, 6'h00);
      capture(RES_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
      check_bits("one_pkt");
      decode(ok, dc, dctl);
      check("one_frame_ok", ok, 1'b1);
      check("one_last_data", dc[7:0], 8'h01);
      check("one_ctl", dctl, 8'h02);

      // error packets with known CTL bytes
      efs[0] = 6'b100100; ectl[0] = 8'hC9;
      efs[1] = 6'b010010; ectl[1] = 8'hA5;
      efs[2] = 6'b001001; ectl[2] = 8'h93;
      for (int i = 0; i < 3; i++) begin
         build_exp(32'hDEAD_BEEF, 4'hF, 1'b1, efs[i]);
         send(32'hDEAD_BEEF, 4'hF, 1'b1, efs[i]);
         capture(FRAME_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
         check_bits("err_pkt");
         decode(ok, dc, dctl);
         check("err_frame_ok", ok, 1'b1);
         check("err_ctl", dctl, ectl[i]);
         check("err_busy_cycles", busy_cycles, 11);
         check_idle("err_end");
      end

      // valid re-pulsed mid-packet is ignored
      build_exp(32'hA5A5_1234, 4'b1010, 1'b0, 6'h00);
      send(32'hA5A5_1234, 4'b1010, 1'b0, 6'h00);
      capture(RES_BITS, 20, 32'h0F0F_FFFF, 4'b0101, 1'b0, 6'h00);
      check_bits("repulse_pkt");
      check("repulse_busy_cycles", busy_cycles, 55);
      check_idle("repulse_end");

      // valid on the final stop-bit edge starts the next packet with no gap
      build_exp(32'h1357_9BDF, 4'b0011, 1'b0, 6'h00);
      send(32'h1357_9BDF, 4'b0011, 1'b0, 6'h00);
      capture(RES_BITS, RES_BITS - 1, 32'h0, 4'h0, 1'b1, 6'b010010);
      check_bits("b2b_first");
      check("b2b_busy_held", bus.busy, 1'b1);
      check("b2b_start_bit", bus.sout, 1'b0);
      build_exp(32'h0, 4'h0, 1'b1, 6'b010010);
      capture(FRAME_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
      check_bits("b2b_second");
      check_idle("b2b_end");

      // reset during DATA bit 3 of frame 2 abandons the packet
      send(32'hCAFE_F00D, 4'b1111, 1'b0, 6'h00);
      capture(2 * FRAME_BITS + 6, -1, 32'd0, 4'd0, 1'b0, 6'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_idle("midrst_now");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle("midrst_after");
      build_exp(32'h8000_0001, 4'b1001, 1'b0, 6'h00);
      send(32'h8000_0001, 4'b1001, 1'b0, 6'h00);
      capture(RES_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
      check_bits("midrst_next_pkt");
      check_idle("midrst_next_end");

      // random loopback through the decoder
      for (int n = 0; n < 1000; n++) begin
         rc = $urandom;
         rf = 4'($urandom);
         send(rc, rf, 1'b0, 6'h00);
         capture(RES_BITS, -1, 32'd0, 4'd0, 1'b0, 6'd0);
         decode(ok, dc, dctl);
         check("rnd_frame_ok", ok, 1'b1);
         check("rnd_c", dc, rc);
         check("rnd_flags", dctl[6:3], rf);
         check("rnd_crc", dctl[2:0], ref_crc(rc, rf));
         check("rnd_marker", dctl[7], 1'b0);
         check("rnd_busy_cycles", busy_cycles, 55);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
